// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-file read stage and alu_seq.
// The master issues operations and consumes results; the slave is the ALU.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       func;
   logic [WIDTH-1:0] operand1;
   logic [WIDTH-1:0] operand2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             eq;
   logic             zero;
   logic             carry;

   modport master (
      output in_valid, func, operand1, operand2, out_ready,
      input  in_ready, out_valid, result, eq, zero, carry
   );

   modport slave (
      input  in_valid, func, operand1, operand2, out_ready,
      output in_ready, out_valid, result, eq, zero, carry
   );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags; logical shifts iterate SHIFT_STEP bits per cycle.
// state | meaning:  IDLE waiting for a request | SHIFT iterating a shift | DONE holding result for consumer
module alu_seq #(
   parameter int WIDTH      = 16,
   parameter int SHIFT_STEP = 1
) (
   input logic      clk,
   input logic      rst,
   alu_seq_if.slave bus
);
   localparam int SW = $clog2(WIDTH);
   localparam int CW = SW + 1;
   localparam logic [CW-1:0]  STEP    = CW'(SHIFT_STEP);
   localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

   localparam logic [2:0] F_ADD   = 3'd0;
   localparam logic [2:0] F_SUB   = 3'd1;
   localparam logic [2:0] F_NAND  = 3'd2;
   localparam logic [2:0] F_PASS1 = 3'd3;
   localparam logic [2:0] F_EQ    = 3'd4;
   localparam logic [2:0] F_LTU   = 3'd5;
   localparam logic [2:0] F_SLL   = 3'd6;
   localparam logic [2:0] F_SRL   = 3'd7;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] acc_q;
   logic [CW-1:0]    rem_q;
   logic             dir_right_q;
   logic [WIDTH-1:0] result_q;
   logic             eq_q;
   logic             zero_q;
   logic             carry_q;
   logic             out_valid_q;

   logic             in_ready;
   logic             accept;
   logic [SW-1:0]    shamt;
   logic             start_shift;
   logic             op_eq;
   logic [WIDTH:0]   sum_add;
   logic [WIDTH:0]   sum_sub;
   logic [WIDTH-1:0] alu_res_d;
   logic             alu_carry_d;
   logic [CW-1:0]    step;
   logic [WIDTH-1:0] acc_d;
   logic [CW-1:0]    rem_d;

   assign in_ready    = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
   assign accept      = bus.in_valid && in_ready;
   assign shamt       = bus.operand2[SW-1:0];
   assign start_shift = ((bus.func == F_SLL) || (bus.func == F_SRL)) && (shamt != '0);
   assign op_eq       = (bus.operand1 == bus.operand2);
   assign sum_add     = {1'b0, bus.operand1} + {1'b0, bus.operand2};
   assign sum_sub     = {1'b0, bus.operand1} + {1'b0, ~bus.operand2} + ONE_EXT;

   always_comb begin
      alu_res_d   = bus.operand1;
      alu_carry_d = 1'b0;
      case (bus.func)
         F_ADD: begin
            alu_res_d   = sum_add[WIDTH-1:0];
            alu_carry_d = sum_add[WIDTH];
         end
         F_SUB: begin
            alu_res_d   = sum_sub[WIDTH-1:0];
            alu_carry_d = sum_sub[WIDTH];
         end
         F_NAND:  alu_res_d = ~(bus.operand1 & bus.operand2);
         F_EQ:    alu_res_d = {{(WIDTH-1){1'b0}}, op_eq};
         F_LTU:   alu_res_d = {{(WIDTH-1){1'b0}}, (bus.operand1 < bus.operand2)};
         // PASS1 and zero-length shifts both return operand1
         default: alu_res_d = bus.operand1;
      endcase
   end

   always_comb begin
      step  = (rem_q < STEP) ? rem_q : STEP;
      acc_d = dir_right_q ? (acc_q >> step) : (acc_q << step);
      rem_d = rem_q - step;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         rem_q       <= '0;
         dir_right_q <= 1'b0;
         result_q    <= '0;
         eq_q        <= 1'b0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (accept) begin
                  eq_q <= op_eq;
                  if (start_shift) begin
                     state_q     <= SHIFT;
                     acc_q       <= bus.operand1;
                     rem_q       <= CW'(shamt);
                     dir_right_q <= bus.func[0];
                     out_valid_q <= 1'b0;
                  end else begin
                     state_q     <= DONE;
                     result_q    <= alu_res_d;
                     zero_q      <= (alu_res_d == '0);
                     carry_q     <= alu_carry_d;
                     out_valid_q <= 1'b1;
                  end
               end else if ((state_q == DONE) && bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            SHIFT: begin
               acc_q <= acc_d;
               rem_q <= rem_d;
               if (rem_d == '0) begin
                  state_q     <= DONE;
                  result_q    <= acc_d;
                  zero_q      <= (acc_d == '0);
                  carry_q     <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.eq        = eq_q;
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vectors, expected responses queued at issue and
// checked by an independent monitor whenever a result is handed off.
module tb_alu_seq;
   localparam logic [2:0] F_ADD   = 3'd0;
   localparam logic [2:0] F_SUB   = 3'd1;
   localparam logic [2:0] F_NAND  = 3'd2;
   localparam logic [2:0] F_PASS1 = 3'd3;
   localparam logic [2:0] F_EQ    = 3'd4;
   localparam logic [2:0] F_LTU   = 3'd5;
   localparam logic [2:0] F_SLL   = 3'd6;
   localparam logic [2:0] F_SRL   = 3'd7;

   typedef struct packed {
      logic [15:0] result;
      logic        eq;
      logic        zero;
      logic        carry;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(16)) bus ();
   alu_seq_if #(.WIDTH(16)) bus4 ();

   alu_seq #(.WIDTH(16), .SHIFT_STEP(1)) dut  (.clk(clk), .rst(rst), .bus(bus));
   alu_seq #(.WIDTH(16), .SHIFT_STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] r, input logic e, input logic z, input logic c);
      exp_t x;
      x.result = r;
      x.eq     = e;
      x.zero   = z;
      x.carry  = c;
      return x;
   endfunction

   // Leaves in_valid high so callers can chain back-to-back requests.
   task automatic issue(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b, input exp_t e);
      int w;
      bus.in_valid = 1'b1;
      bus.func     = f;
      bus.operand1 = a;
      bus.operand2 = b;
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 200) begin
         w++;
         @(negedge clk);
      end
      check("accept_wait", bus.in_ready, 1);
      if (bus.in_ready) sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_unexpected: result 0x%0h with no pending expectation", bus.result);
            end else begin
               e = sb.pop_front();
               check("sb_result", bus.result, e.result);
               check("sb_eq",     bus.eq,     e.eq);
               check("sb_zero",   bus.zero,   e.zero);
               check("sb_carry",  bus.carry,  e.carry);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      int bad;
      int w;
      rst = 1'b1;
      bus.in_valid  = 1'b0; bus.func  = 3'd0; bus.operand1  = '0; bus.operand2  = '0; bus.out_ready  = 1'b1;
      bus4.in_valid = 1'b0; bus4.func = 3'd0; bus4.operand1 = '0; bus4.operand2 = '0; bus4.out_ready = 1'b1;
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_result",    bus.result,    0);
      check("rst_eq",        bus.eq,        0);
      check("rst_zero",      bus.zero,      0);
      check("rst_carry",     bus.carry,     0);
      check("rst_in_ready",  bus.in_ready,  1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // single-cycle ops, streamed back-to-back
      issue(F_ADD, 16'hFFFF, 16'h0001, mk(16'h0000, 0, 1, 1));
      check("add_latency_valid", bus.out_valid, 1);
      issue(F_SUB,   16'h0005, 16'h0007, mk(16'hFFFE, 0, 0, 0));
      issue(F_LTU,   16'h0005, 16'h0007, mk(16'h0001, 0, 0, 0));
      issue(F_SUB,   16'h0005, 16'h0005, mk(16'h0000, 1, 1, 1));
      issue(F_EQ,    16'h1234, 16'h1234, mk(16'h0001, 1, 0, 0));
      issue(F_ADD,   16'h1234, 16'h4321, mk(16'h5555, 0, 0, 0));
      issue(F_PASS1, 16'h0000, 16'hAAAA, mk(16'h0000, 0, 1, 0));
      issue(F_SLL,   16'h1234, 16'h0010, mk(16'h1234, 0, 0, 0));
      issue(F_LTU,   16'h0007, 16'h0005, mk(16'h0000, 0, 1, 0));
      idle();
      @(posedge clk); #1;

      // SLL by 15 (upper operand2 bits ignored), SHIFT_STEP=1
      issue(F_SLL, 16'h0001, 16'h123F, mk(16'h8000, 0, 0, 0));
      idle();
      n = 1; bad = 0;
      while (!bus.out_valid && n < 100) begin
         if (bus.in_ready) bad++;
         @(posedge clk); #1;
         n++;
      end
      check("sll15_latency", n, 16);
      check("sll15_in_ready_low", bad, 0);
      @(posedge clk); #1;
      issue(F_SRL, 16'h8000, 16'h0004, mk(16'h0800, 0, 0, 0));
      issue(F_SLL, 16'h8000, 16'h0001, mk(16'h0000, 0, 1, 0));
      idle();
      w = 0;
      while (!bus.out_valid && w < 50) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;

      // SHIFT_STEP=4 instance
      bus4.in_valid = 1'b1; bus4.func = F_SLL; bus4.operand1 = 16'h0001; bus4.operand2 = 16'h000F;
      @(negedge clk);
      check("step4_in_ready", bus4.in_ready, 1);
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      n = 1;
      while (!bus4.out_valid && n < 100) begin @(posedge clk); #1; n++; end
      check("step4_sll15_latency", n, 5);
      check("step4_sll15_result", bus4.result, 16'h8000);
      @(posedge clk); #1;
      bus4.in_valid = 1'b1; bus4.func = F_SRL; bus4.operand1 = 16'hFFFF; bus4.operand2 = 16'h0006;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      n = 1;
      while (!bus4.out_valid && n < 100) begin @(posedge clk); #1; n++; end
      check("step4_srl6_latency", n, 3);
      check("step4_srl6_result", bus4.result, 16'h03FF);

      // NAND held under backpressure, then ADD accepted on the release edge
      bus.out_ready = 1'b0;
      issue(F_NAND, 16'h00FF, 16'h0F0F, mk(16'hFFF0, 0, 0, 0));
      bus.func = F_ADD; bus.operand1 = 16'h1000; bus.operand2 = 16'h2000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid",    bus.out_valid, 1);
         check("hold_result",   bus.result,    16'hFFF0);
         check("hold_in_ready", bus.in_ready,  0);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      issue(F_ADD, 16'h1000, 16'h2000, mk(16'h3000, 0, 0, 0));
      check("b2b_valid",  bus.out_valid, 1);
      check("b2b_result", bus.result,    16'h3000);

      // eight back-to-back PASS1 ops, no bubbles
      for (int i = 0; i < 8; i++) begin
         issue(F_PASS1, 16'(i * 16'h1111 + 1), 16'(i), mk(16'(i * 16'h1111 + 1), 0, 0, 0));
         check("stream_valid",  bus.out_valid, 1);
         check("stream_result", bus.result,    16'(i * 16'h1111 + 1));
      end
      idle();
      @(posedge clk); #1;

      // async reset three cycles into SRL 0x8000 by 10
      issue(F_SRL, 16'h8000, 16'h000A, mk(16'h0020, 0, 0, 0));
      idle();
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_result",    bus.result,    0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("postrst_in_ready",  bus.in_ready,  1);
      check("postrst_out_valid", bus.out_valid, 0);
      @(posedge clk); #1;
      issue(F_PASS1, 16'hBEEF, 16'h0000, mk(16'hBEEF, 0, 0, 0));
      idle();
      check("postrst_pass_valid", bus.out_valid, 1);

      w = 0;
      while (sb.size() != 0 && w < 50) begin @(posedge clk); w++; end
      check("sb_drained", sb.size(), 0);
      @(posedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
